// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core load/store path, the DMA master and the data memory.
// slave = arbiter view, master = requesters + memory view.
interface dmem_arbiter_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  c_req, c_we, c_gnt, c_rvalid;
  logic [DM_ADDRESS-1:0] c_addr;
  logic [DATA_W-1:0]     c_wdata, c_rdata;
  logic [2:0]            c_funct3;

  logic                  d_req, d_we, d_lock, d_gnt, d_rvalid;
  logic [DM_ADDRESS-1:0] d_addr;
  logic [DATA_W-1:0]     d_wdata, d_rdata;
  logic [2:0]            d_funct3;

  logic                  MemRead, MemWrite;
  logic [DM_ADDRESS-1:0] a;
  logic [DATA_W-1:0]     wd, rd;
  logic [2:0]            Funct3;

  // Handshake: req and its fields stay stable until the cycle gnt=1; the access
  // happens in that cycle and a load answers with a one-cycle rvalid one cycle later.
  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_funct3,
    input  d_req, d_we, d_addr, d_wdata, d_funct3, d_lock,
    input  rd,
    output c_gnt, c_rvalid, c_rdata, d_gnt, d_rvalid, d_rdata,
    output MemRead, MemWrite, a, wd, Funct3
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, c_funct3,
    output d_req, d_we, d_addr, d_wdata, d_funct3, d_lock,
    output rd,
    input  c_gnt, c_rvalid, c_rdata, d_gnt, d_rvalid, d_rdata,
    input  MemRead, MemWrite, a, wd, Funct3
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-ported data memory with bounded locked DMA bursts.
// Define DMEM_ARB_RR_EN for round-robin IDLE arbitration (default: fixed core priority).
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic         clk,
  input  logic         reset,
  dmem_arbiter_if.slave bus,
  output logic [1:0]   dbg_st_o,
  output logic [3:0]   dbg_bcnt_o
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BURST = 2'd1, ST_YIELD = 2'd2} st_e;

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  st_e                   st_q;
  logic [3:0]            bcnt_q;
  logic                  c_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0]     c_rdata_q, d_rdata_q;
  logic                  c_gnt_w, d_gnt_w;
  logic [3:0]            bcnt_inc;
  logic                  mem_we;
  logic [DM_ADDRESS-1:0] mem_a;
  logic [DATA_W-1:0]     mem_wd;
  logic [2:0]            mem_f3;
`ifdef DMEM_ARB_RR_EN
  logic                  last_d_q;
`endif

  assign bcnt_inc = bcnt_q + 4'd1;

  // Grants are held low throughout reset so nothing reaches memory in that cycle.
  always_comb begin
    c_gnt_w = 1'b0;
    d_gnt_w = 1'b0;
    if (!reset) begin
      case (st_q)
        ST_IDLE: begin
`ifdef DMEM_ARB_RR_EN
          c_gnt_w = bus.c_req & (~bus.d_req | last_d_q);
`else
          c_gnt_w = bus.c_req;
`endif
          d_gnt_w = bus.d_req & ~c_gnt_w;
        end
        ST_BURST: d_gnt_w = bus.d_req;
        ST_YIELD: c_gnt_w = bus.c_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    mem_f3 = '0;
    if (c_gnt_w) begin
      mem_we = bus.c_we;
      mem_a  = bus.c_addr;
      mem_wd = bus.c_wdata;
      mem_f3 = bus.c_funct3;
    end else if (d_gnt_w) begin
      mem_we = bus.d_we;
      mem_a  = bus.d_addr;
      mem_wd = bus.d_wdata;
      mem_f3 = bus.d_funct3;
    end
  end

  assign bus.MemRead  = (c_gnt_w | d_gnt_w) & ~mem_we;
  assign bus.MemWrite = (c_gnt_w | d_gnt_w) & mem_we;
  assign bus.a        = mem_a;
  assign bus.wd       = mem_wd;
  assign bus.Funct3   = mem_f3;
  assign bus.c_gnt    = c_gnt_w;
  assign bus.d_gnt    = d_gnt_w;
  assign bus.c_rvalid = c_rvalid_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.c_rdata  = c_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign dbg_st_o     = st_q;
  assign dbg_bcnt_o   = bcnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= ST_IDLE;
      bcnt_q     <= 4'd0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
`ifdef DMEM_ARB_RR_EN
      last_d_q   <= 1'b1;
`endif
    end else begin
      c_rvalid_q <= c_gnt_w & ~bus.c_we;
      d_rvalid_q <= d_gnt_w & ~bus.d_we;
      if (c_gnt_w && !bus.c_we) c_rdata_q <= bus.rd;
      if (d_gnt_w && !bus.d_we) d_rdata_q <= bus.rd;
`ifdef DMEM_ARB_RR_EN
      if (c_gnt_w)      last_d_q <= 1'b0;
      else if (d_gnt_w) last_d_q <= 1'b1;
`endif
      case (st_q)
        ST_IDLE: begin
          if (d_gnt_w && bus.d_lock) begin
            bcnt_q <= 4'd1;
            st_q   <= (MAX_B == 4'd1) ? ST_YIELD : ST_BURST;
          end
        end
        // Reaching the beat limit forces a yield even if the master also drops lock.
        ST_BURST: begin
          if (!bus.d_req) begin
            st_q   <= ST_IDLE;
            bcnt_q <= 4'd0;
          end else if (bcnt_inc == MAX_B) begin
            st_q   <= ST_YIELD;
            bcnt_q <= bcnt_inc;
          end else if (!bus.d_lock) begin
            st_q   <= ST_IDLE;
            bcnt_q <= 4'd0;
          end else begin
            bcnt_q <= bcnt_inc;
          end
        end
        ST_YIELD: begin
          st_q   <= ST_IDLE;
          bcnt_q <= 4'd0;
        end
        default: begin
          st_q   <= ST_IDLE;
          bcnt_q <= 4'd0;
        end
      endcase
    end
  end
endmodule
